mem_port_arbiter: RTL and testbench

- Parametrised arbiter that lets NCH pipeline requesters (IF fetch, EX load/store, future MMU/cache refill) share one SRAM-style memory port.
- It replaces the direct one-stage-per-SRAM wiring at the CPU top.
- Adds fixed-priority or round-robin arbitration, a configurable memory read latency, and in-order response routing back to the issuing channel.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of mem_port_arbiter.
//   master : the environment (pipeline requesters plus the SRAM). It drives the
//            requests and mem_rdata, and observes grants, responses and the
//            memory command.
//   slave  : the arbiter itself.
// Signals:
//   req_valid/req_ready  per-channel request handshake
//   req_we               per-channel byte enables, channel i at [i*DW/8 +: DW/8]
//   req_addr/req_wdata   per-channel address and write data, packed by channel
//   resp_valid           one-hot response strobe to the owning channel
//   resp_rdata           shared response data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata            memory read data
interface mem_port_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH*DW/8-1:0]   req_we;
  logic [NCH*AW-1:0]     req_addr;
  logic [NCH*DW-1:0]     req_wdata;
  logic [NCH-1:0]        resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic                  mem_en;
  logic [DW/8-1:0]       mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-style memory port between NCH pipeline requesters.
// Arbitration is combinational (fixed priority or round-robin), one access is
// issued per cycle, and responses are routed back in issue order after LAT
// cycles through a small shift pipeline of {valid, chan_id, is_write}.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     mem_port_arbiter_if slave modport (requests, responses, memory)
module mem_port_arbiter #(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LAT       = 1,
  parameter int PRIO_MODE = 0
) (
  input logic               clk,
  input logic               resetn,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = DW / 8;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0] rr_ptr;
  logic          fix_any, rr_any, gnt_any;
  logic [CW-1:0] fix_idx, rr_idx, gnt_idx;

  logic [BW-1:0] sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic [LAT-1:0] pipe_v;
  logic [LAT-1:0] pipe_w;
  logic [CW-1:0]  pipe_c [LAT];

  // Fixed priority: scanning downwards leaves the lowest valid index.
  always_comb begin
    fix_any = 1'b0;
    fix_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        fix_any = 1'b1;
        fix_idx = CW'(i);
      end
    end
  end

  // Round-robin: offsets are scanned from farthest to nearest so the channel
  // closest after rr_ptr is the one left standing.
  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    for (int k = NCH; k >= 1; k--) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.req_valid[i] && (((int'(rr_ptr) + k) % NCH) == i)) begin
          rr_any = 1'b1;
          rr_idx = CW'(i);
        end
      end
    end
  end

  // Grants are suppressed combinationally while reset is held.
  assign gnt_any = resetn & ((PRIO_MODE == 1) ? rr_any : fix_any);
  assign gnt_idx = (PRIO_MODE == 1) ? rr_idx : fix_idx;

  always_comb begin
    bus.req_ready = '0;
    sel_we        = '0;
    sel_addr      = '0;
    sel_wdata     = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_any && (gnt_idx == CW'(i))) begin
        bus.req_ready[i] = 1'b1;
        sel_we           = bus.req_we[i*BW +: BW];
        sel_addr         = bus.req_addr[i*AW +: AW];
        sel_wdata        = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  assign bus.mem_en    = resetn & (|bus.req_valid);
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      pipe_w <= '0;
      for (int s = 0; s < LAT; s++) begin
        pipe_c[s] <= '0;
      end
      rr_ptr <= CW'(NCH - 1);
    end else begin
      pipe_v[0] <= gnt_any;
      pipe_w[0] <= |sel_we;
      pipe_c[0] <= gnt_idx;
      for (int s = 1; s < LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_w[s] <= pipe_w[s-1];
        pipe_c[s] <= pipe_c[s-1];
      end
      if (gnt_any) begin
        rr_ptr <= gnt_idx;
      end
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.resp_valid[i] = pipe_v[LAT-1] && (pipe_c[LAT-1] == CW'(i));
    end
  end

  // Writes get an acknowledge with zero data; memory data only passes for reads.
  assign bus.resp_rdata = (pipe_v[LAT-1] && !pipe_w[LAT-1]) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Five instances cover the
// configurations exercised: fixed/NCH2/LAT1, RR/NCH3/LAT1, fixed/NCH2/LAT3,
// RR/NCH2/LAT2 (with its own reset), and NCH1/LAT1. Each has a memory model
// returning addr ^ 0xFFFF after LAT cycles and a response scoreboard.
module tb_mem_port_arbiter;
  typedef struct packed {
    logic [7:0]  oh;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_l2;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCH(2), .AW(32), .DW(32)) b_fix ();
  mem_port_arbiter_if #(.NCH(3), .AW(32), .DW(32)) b_rr ();
  mem_port_arbiter_if #(.NCH(2), .AW(32), .DW(32)) b_l3 ();
  mem_port_arbiter_if #(.NCH(2), .AW(32), .DW(32)) b_l2 ();
  mem_port_arbiter_if #(.NCH(1), .AW(32), .DW(32)) b_one ();

  mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .LAT(1), .PRIO_MODE(0))
    u_fix (.clk(clk), .resetn(rst_n), .bus(b_fix));
  mem_port_arbiter #(.NCH(3), .AW(32), .DW(32), .LAT(1), .PRIO_MODE(1))
    u_rr (.clk(clk), .resetn(rst_n), .bus(b_rr));
  mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .LAT(3), .PRIO_MODE(0))
    u_l3 (.clk(clk), .resetn(rst_n), .bus(b_l3));
  mem_port_arbiter #(.NCH(2), .AW(32), .DW(32), .LAT(2), .PRIO_MODE(1))
    u_l2 (.clk(clk), .resetn(rst_l2), .bus(b_l2));
  mem_port_arbiter #(.NCH(1), .AW(32), .DW(32), .LAT(1), .PRIO_MODE(0))
    u_one (.clk(clk), .resetn(rst_n), .bus(b_one));

  // Memory models: address delayed LAT cycles, data = addr ^ 0xFFFF.
  logic [31:0] m_fix, m_rr, m_one;
  logic [31:0] m_l3 [3];
  logic [31:0] m_l2 [2];

  always @(posedge clk) begin
    m_fix   <= b_fix.mem_addr;
    m_rr    <= b_rr.mem_addr;
    m_one   <= b_one.mem_addr;
    m_l3[0] <= b_l3.mem_addr;
    m_l3[1] <= m_l3[0];
    m_l3[2] <= m_l3[1];
    m_l2[0] <= b_l2.mem_addr;
    m_l2[1] <= m_l2[0];
  end

  assign b_fix.mem_rdata = m_fix ^ 32'hFFFF;
  assign b_rr.mem_rdata  = m_rr ^ 32'hFFFF;
  assign b_one.mem_rdata = m_one ^ 32'hFFFF;
  assign b_l3.mem_rdata  = m_l3[2] ^ 32'hFFFF;
  assign b_l2.mem_rdata  = m_l2[1] ^ 32'hFFFF;

  exp_t q_fix[$];
  exp_t q_rr[$];
  exp_t q_l3[$];
  exp_t q_l2[$];
  exp_t q_one[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [7:0] oh, input logic [31:0] data);
    exp_t e;
    e.oh   = oh;
    e.data = data;
    return e;
  endfunction

  // Scoreboard monitors: every strobe must match the oldest expected response.
  exp_t e_fix, e_rr, e_l3, e_l2, e_one;

  always @(negedge clk) begin
    if (b_fix.resp_valid != '0) begin
      if (q_fix.size() == 0) chk("fix_unexpected_resp", 64'(b_fix.resp_valid), 64'd0);
      else begin
        e_fix = q_fix.pop_front();
        chk("fix_resp_valid", 64'(b_fix.resp_valid), 64'(e_fix.oh));
        chk("fix_resp_rdata", 64'(b_fix.resp_rdata), 64'(e_fix.data));
      end
    end
  end

  always @(negedge clk) begin
    if (b_rr.resp_valid != '0) begin
      if (q_rr.size() == 0) chk("rr_unexpected_resp", 64'(b_rr.resp_valid), 64'd0);
      else begin
        e_rr = q_rr.pop_front();
        chk("rr_resp_valid", 64'(b_rr.resp_valid), 64'(e_rr.oh));
        chk("rr_resp_rdata", 64'(b_rr.resp_rdata), 64'(e_rr.data));
      end
    end
  end

  always @(negedge clk) begin
    if (b_l3.resp_valid != '0) begin
      if (q_l3.size() == 0) chk("l3_unexpected_resp", 64'(b_l3.resp_valid), 64'd0);
      else begin
        e_l3 = q_l3.pop_front();
        chk("l3_resp_valid", 64'(b_l3.resp_valid), 64'(e_l3.oh));
        chk("l3_resp_rdata", 64'(b_l3.resp_rdata), 64'(e_l3.data));
      end
    end
  end

  always @(negedge clk) begin
    if (b_l2.resp_valid != '0) begin
      if (q_l2.size() == 0) chk("l2_unexpected_resp", 64'(b_l2.resp_valid), 64'd0);
      else begin
        e_l2 = q_l2.pop_front();
        chk("l2_resp_valid", 64'(b_l2.resp_valid), 64'(e_l2.oh));
        chk("l2_resp_rdata", 64'(b_l2.resp_rdata), 64'(e_l2.data));
      end
    end
  end

  always @(negedge clk) begin
    if (b_one.resp_valid != '0) begin
      if (q_one.size() == 0) chk("one_unexpected_resp", 64'(b_one.resp_valid), 64'd0);
      else begin
        e_one = q_one.pop_front();
        chk("one_resp_valid", 64'(b_one.resp_valid), 64'(e_one.oh));
        chk("one_resp_rdata", 64'(b_one.resp_rdata), 64'(e_one.data));
      end
    end
  end

  task automatic clear_inputs();
    b_fix.req_valid = '0; b_fix.req_we = '0; b_fix.req_addr = '0; b_fix.req_wdata = '0;
    b_rr.req_valid  = '0; b_rr.req_we  = '0; b_rr.req_addr  = '0; b_rr.req_wdata  = '0;
    b_l3.req_valid  = '0; b_l3.req_we  = '0; b_l3.req_addr  = '0; b_l3.req_wdata  = '0;
    b_l2.req_valid  = '0; b_l2.req_we  = '0; b_l2.req_addr  = '0; b_l2.req_wdata  = '0;
    b_one.req_valid = '0; b_one.req_we = '0; b_one.req_addr = '0; b_one.req_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int          rr_g  [9] = '{0, 1, 2, 0, 1, 2, 2, 2, 2};
  int          l3_ch [3] = '{0, 1, 0};
  logic [31:0] l3_a  [3] = '{32'h100, 32'h104, 32'h108};
  logic [31:0] l3_d  [3] = '{32'hFEFF, 32'hFEFB, 32'hFEF7};

  initial begin
    logic [31:0] a;
    logic [7:0]  oh;
    rst_n  = 1'b0;
    rst_l2 = 1'b0;
    clear_inputs();

    // Reset: requests present but nothing granted or issued.
    b_fix.req_valid = 2'b11;
    b_one.req_valid = 1'b1;
    @(negedge clk);
    chk("rst_fix_ready",  64'(b_fix.req_ready), 64'd0);
    chk("rst_fix_mem_en", 64'(b_fix.mem_en), 64'd0);
    chk("rst_fix_resp",   64'(b_fix.resp_valid), 64'd0);
    chk("rst_one_ready",  64'(b_one.req_ready), 64'd0);
    next_cycle();
    clear_inputs();
    rst_n  = 1'b1;
    rst_l2 = 1'b1;
    next_cycle();

    // Fixed priority: channel 1 starved while channel 0 is valid.
    for (int c = 0; c < 3; c++) begin
      a = 32'h10 + 32'(4 * c);
      b_fix.req_valid = 2'b11;
      b_fix.req_addr  = {32'h200, a};
      q_fix.push_back(mk(8'h01, a ^ 32'hFFFF));
      @(negedge clk);
      chk("fix_both_ready", 64'(b_fix.req_ready), 64'h1);
      chk("fix_mem_en",     64'(b_fix.mem_en), 64'h1);
      next_cycle();
    end
    b_fix.req_valid = 2'b10;
    b_fix.req_addr  = {32'h200, 32'h0};
    q_fix.push_back(mk(8'h02, 32'h200 ^ 32'hFFFF));
    @(negedge clk);
    chk("fix_ch1_after_drop", 64'(b_fix.req_ready), 64'h2);
    chk("fix_ch1_addr",       64'(b_fix.mem_addr), 64'h200);
    next_cycle();

    // Write from channel 1 at LAT=1, acknowledged with zero data.
    b_fix.req_valid = 2'b10;
    b_fix.req_we    = {4'hF, 4'h0};
    b_fix.req_addr  = {32'h20, 32'h0};
    b_fix.req_wdata = {32'hDEADBEEF, 32'h0};
    q_fix.push_back(mk(8'h02, 32'h0));
    @(negedge clk);
    chk("wr_mem_we",    64'(b_fix.mem_we), 64'hF);
    chk("wr_mem_wdata", 64'(b_fix.mem_wdata), 64'hDEADBEEF);
    chk("wr_mem_addr",  64'(b_fix.mem_addr), 64'h20);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("wr_ack_valid", 64'(b_fix.resp_valid), 64'h2);
    chk("wr_ack_rdata", 64'(b_fix.resp_rdata), 64'h0);
    chk("idle_mem_en",  64'(b_fix.mem_en), 64'h0);
    chk("idle_mem_we",  64'(b_fix.mem_we), 64'h0);
    next_cycle();

    // Round-robin over three channels, then channel 2 alone.
    for (int c = 0; c < 9; c++) begin
      b_rr.req_valid = (c < 6) ? 3'b111 : 3'b100;
      b_rr.req_addr  = {32'h3000 + 32'(4 * c), 32'h2000 + 32'(4 * c), 32'h1000 + 32'(4 * c)};
      oh = 8'(1 << rr_g[c]);
      q_rr.push_back(mk(oh, (32'h1000 * 32'(rr_g[c] + 1) + 32'(4 * c)) ^ 32'hFFFF));
      @(negedge clk);
      chk("rr_grant", 64'(b_rr.req_ready), 64'(oh));
      next_cycle();
    end
    clear_inputs();

    // LAT=3 back-to-back reads: responses on cycles 3, 4, 5 after first accept.
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        b_l3.req_valid = 2'(1 << l3_ch[c]);
        b_l3.req_addr  = (l3_ch[c] == 0) ? {32'h0, l3_a[c]} : {l3_a[c], 32'h0};
        q_l3.push_back(mk(8'(1 << l3_ch[c]), l3_d[c]));
      end else begin
        b_l3.req_valid = '0;
      end
      @(negedge clk);
      if (c < 3) chk("l3_ready", 64'(b_l3.req_ready), 64'(1 << l3_ch[c]));
      if (c >= 3 && c < 6) begin
        chk("l3_resp_timing", 64'(b_l3.resp_valid), 64'(1 << l3_ch[c-3]));
        chk("l3_resp_data",   64'(b_l3.resp_rdata), 64'(l3_d[c-3]));
      end else begin
        chk("l3_resp_quiet",  64'(b_l3.resp_valid), 64'h0);
      end
      next_cycle();
    end
    clear_inputs();

    // LAT=2 RR: two reads in flight are dropped by a reset pulse.
    b_l2.req_valid = 2'b10;
    b_l2.req_addr  = {32'h44, 32'h0};
    @(negedge clk);
    chk("l2_pre_grant_ch1", 64'(b_l2.req_ready), 64'h2);
    next_cycle();
    b_l2.req_valid = 2'b01;
    b_l2.req_addr  = {32'h0, 32'h40};
    @(negedge clk);
    chk("l2_pre_grant_ch0", 64'(b_l2.req_ready), 64'h1);
    next_cycle();
    rst_l2 = 1'b0;
    b_l2.req_valid = '0;
    @(negedge clk);
    chk("l2_resp_in_reset", 64'(b_l2.resp_valid), 64'h0);
    next_cycle();
    rst_l2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("l2_resp_after_reset", 64'(b_l2.resp_valid), 64'h0);
      next_cycle();
    end
    b_l2.req_valid = 2'b11;
    b_l2.req_addr  = {32'h84, 32'h80};
    q_l2.push_back(mk(8'h01, 32'h80 ^ 32'hFFFF));
    @(negedge clk);
    chk("l2_first_rr_after_reset", 64'(b_l2.req_ready), 64'h1);
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();

    // NCH=1 pass-through: responses on consecutive cycles in order.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        b_one.req_valid = 1'b1;
        b_one.req_addr  = 32'(c);
        q_one.push_back(mk(8'h01, 32'(c) ^ 32'hFFFF));
      end else begin
        b_one.req_valid = 1'b0;
      end
      @(negedge clk);
      chk("one_ready_follows_valid", 64'(b_one.req_ready), 64'(b_one.req_valid));
      if (c >= 1 && c <= 8) begin
        chk("one_resp_consecutive", 64'(b_one.resp_valid), 64'h1);
        chk("one_resp_order",       64'(b_one.resp_rdata), 64'(32'(c - 1) ^ 32'hFFFF));
      end else begin
        chk("one_resp_quiet", 64'(b_one.resp_valid), 64'h0);
      end
      next_cycle();
    end
    clear_inputs();
    repeat (5) next_cycle();

    chk("q_fix_drained", 64'(q_fix.size()), 64'd0);
    chk("q_rr_drained",  64'(q_rr.size()), 64'd0);
    chk("q_l3_drained",  64'(q_l3.size()), 64'd0);
    chk("q_l2_drained",  64'(q_l2.size()), 64'd0);
    chk("q_one_drained", 64'(q_one.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
